// File: rtl/vx_tma_copy_sched.sv
// vx_tma_copy_sched
// Sequencer for TMA bulk-copy commands. One command at a time is split into
// per-word reads on a shared memory port; every returned word is written back
// to the destination on the same port. A small slot table bounds the number
// of reads in flight and holds returned data until its write is issued.
// Completion is reported through a valid/ready done handshake.

module vx_tma_copy_sched #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16,
    parameter int TAG_WIDTH  = 8,
    parameter int MAX_OUTS   = 4,
    localparam int SLOT_BITS = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_src_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_dst_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [TAG_WIDTH-1:0]  cmd_tag,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_rw,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_data,
    output logic [SLOT_BITS-1:0]  mem_req_tag,

    input  logic                  mem_rsp_valid,
    output logic                  mem_rsp_ready,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    input  logic [SLOT_BITS-1:0]  mem_rsp_tag,

    output logic                  done_valid,
    input  logic                  done_ready,
    output logic [TAG_WIDTH-1:0]  done_tag,

    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [1:0] {SLOT_FREE, SLOT_PEND, SLOT_FULL} slot_st_t;

    // One extra bit so a maximal-length command still reaches its count.
    typedef logic [LEN_WIDTH:0] cnt_t;
    localparam cnt_t CNT_ONE = cnt_t'(1);

    state_t                state_q, state_d;

    logic [ADDR_WIDTH-1:0] src_q, dst_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    cnt_t                  rd_cnt_q, wr_cnt_q;

    slot_st_t              slot_st_q   [MAX_OUTS];
    logic [LEN_WIDTH-1:0]  slot_off_q  [MAX_OUTS];
    logic [DATA_WIDTH-1:0] slot_data_q [MAX_OUTS];

    // A request left waiting on mem_req_ready is frozen here so that a
    // response landing meanwhile cannot change what is being presented.
    logic                  hold_q;
    logic                  hold_rw_q;
    logic [SLOT_BITS-1:0]  hold_slot_q;

    logic                  full_found, free_found;
    logic [SLOT_BITS-1:0]  full_idx, free_idx;
    logic                  rd_left;
    logic                  sel_rw;
    logic [SLOT_BITS-1:0]  sel_slot;

    logic                  cmd_fire, rd_fire, wr_fire, last_wr, rsp_accept;

    assign cmd_fire   = cmd_valid && cmd_ready;
    assign rd_fire    = mem_req_valid && mem_req_ready && !sel_rw;
    assign wr_fire    = mem_req_valid && mem_req_ready && sel_rw;
    assign last_wr    = wr_fire && ((wr_cnt_q + CNT_ONE) == {1'b0, len_q});
    assign rd_left    = rd_cnt_q < {1'b0, len_q};
    assign rsp_accept = mem_rsp_valid && (slot_st_q[mem_rsp_tag] == SLOT_PEND);

    assign mem_rsp_ready = 1'b1;

    // Lowest-index FULL and FREE slots (downward scan: the last hit wins).
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        full_found = 1'b0;
        free_found = 1'b0;
        full_idx   = '0;
        free_idx   = '0;
        for (int i = MAX_OUTS - 1; i >= 0; i--) begin
            if (slot_st_q[i] == SLOT_FULL) begin
                full_found = 1'b1;
                full_idx   = SLOT_BITS'(i);
            end
            if (slot_st_q[i] == SLOT_FREE) begin
                free_found = 1'b1;
                free_idx   = SLOT_BITS'(i);
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (cmd_fire) state_d = (cmd_len != '0) ? RUN : DONE;
            RUN:  if (last_wr) state_d = DONE;
            DONE: if (done_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshakes, status and the request mux (write first).
    always_comb begin
        cmd_ready     = (state_q == IDLE);
        done_valid    = (state_q == DONE);
        done_tag      = (state_q == DONE) ? tag_q : '0;
        busy          = (state_q != IDLE);
        mem_req_valid = 1'b0;
        sel_rw        = 1'b0;
        sel_slot      = '0;
        if (state_q == RUN) begin
            if (hold_q) begin
                mem_req_valid = 1'b1;
                sel_rw        = hold_rw_q;
                sel_slot      = hold_slot_q;
            end else if (full_found) begin
                mem_req_valid = 1'b1;
                sel_rw        = 1'b1;
                sel_slot      = full_idx;
            end else if (rd_left && free_found) begin
                mem_req_valid = 1'b1;
                sel_rw        = 1'b0;
                sel_slot      = free_idx;
            end
        end
        mem_req_rw   = sel_rw;
        mem_req_tag  = sel_slot;
        mem_req_addr = sel_rw ? (dst_q + ADDR_WIDTH'(slot_off_q[sel_slot]))
                              : (src_q + ADDR_WIDTH'(rd_cnt_q));
        mem_req_data = sel_rw ? slot_data_q[sel_slot] : '0;
    end

    // Command fields, progress counters and the stall hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            tag_q       <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            hold_q      <= 1'b0;
            hold_rw_q   <= 1'b0;
            hold_slot_q <= '0;
        end else begin
            if (cmd_fire) begin
                src_q    <= cmd_src_addr;
                dst_q    <= cmd_dst_addr;
                len_q    <= cmd_len;
                tag_q    <= cmd_tag;
                rd_cnt_q <= '0;
                wr_cnt_q <= '0;
            end
            if (rd_fire) rd_cnt_q <= rd_cnt_q + CNT_ONE;
            if (wr_fire) wr_cnt_q <= wr_cnt_q + CNT_ONE;
            hold_q      <= mem_req_valid && !mem_req_ready;
            hold_rw_q   <= sel_rw;
            hold_slot_q <= sel_slot;
        end
    end

    // Slot life cycle: FREE -> PEND on read fire, PEND -> FULL on response,
    // FULL -> FREE on write fire. The three never hit the same slot at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_OUTS; i++) slot_st_q[i] <= SLOT_FREE;
        end else begin
            if (rd_fire)    slot_st_q[sel_slot]    <= SLOT_PEND;
            if (wr_fire)    slot_st_q[sel_slot]    <= SLOT_FREE;
            if (rsp_accept) slot_st_q[mem_rsp_tag] <= SLOT_FULL;
        end
    end

    // Slot payload: word offset captured at read issue, data at response.
    // NOTE: payload arrays carry no reset; the status above gates every use.
    always_ff @(posedge clk) begin
        if (rd_fire)    slot_off_q[sel_slot]     <= rd_cnt_q[LEN_WIDTH-1:0];
        if (rsp_accept) slot_data_q[mem_rsp_tag] <= mem_rsp_data;
    end

    // A response outside IDLE must address a pending slot; stale responses
    // following a reset arrive while IDLE and are silently dropped.
    assert property (@(posedge clk) disable iff (!reset)
        (mem_rsp_valid && (state_q != IDLE)) |-> (slot_st_q[mem_rsp_tag] == SLOT_PEND));

endmodule

// File: tb/tb_vx_tma_copy_sched.sv
// tb_vx_tma_copy_sched
// Bench for the TMA copy sequencer. A memory model on the falling edge plays
// the memory port (random or forced responses, random or stalled ready) and
// keeps a slot/offset view of the copy, from which it predicts every request.

module tb_vx_tma_copy_sched;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 16;
    localparam int TW = 8;
    localparam int NS = 4;
    localparam int SB = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready;
    logic [AW-1:0] cmd_src_addr, cmd_dst_addr;
    logic [LW-1:0] cmd_len;
    logic [TW-1:0] cmd_tag;
    logic          mem_req_valid, mem_req_ready, mem_req_rw;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_data;
    logic [SB-1:0] mem_req_tag;
    logic          mem_rsp_valid, mem_rsp_ready;
    logic [DW-1:0] mem_rsp_data;
    logic [SB-1:0] mem_rsp_tag;
    logic          done_valid, done_ready;
    logic [TW-1:0] done_tag;
    logic          busy;

    always #5 clk = ~clk;

    vx_tma_copy_sched #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TAG_WIDTH(TW), .MAX_OUTS(NS)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr),
        .cmd_len(cmd_len), .cmd_tag(cmd_tag),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
        .done_valid(done_valid), .done_ready(done_ready), .done_tag(done_tag),
        .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    typedef enum logic [1:0] {M_FREE, M_PEND, M_FULL} mslot_e;
    typedef struct packed {logic rw; logic [SB-1:0] tag; logic [AW-1:0] addr; logic [DW-1:0] data;} txn_t;
    typedef struct packed {logic [SB-1:0] tag; logic [DW-1:0] data;} frsp_t;

    mslot_e        m_st   [NS];
    logic [31:0]   m_off  [NS];
    logic [31:0]   m_data [NS];
    int            m_due  [NS];
    logic          m_active = 1'b0;
    logic [31:0]   m_src, m_dst;
    int            m_len = 0, m_rd = 0, m_wr = 0;
    logic [31:0]   src_mem [logic [31:0]];
    txn_t          txn_log [$];
    frsp_t         force_q [$];

    bit            rsp_auto = 1'b1;
    bit            rdy_rand = 1'b1;
    int            lat_min = 1, lat_max = 6;
    int            stall_until = 0;
    int            cyc = 0;
    logic          prev_hold = 1'b0;
    txn_t          prev_fields;

    always @(posedge clk) cyc++;

    // Source memory contents: explicit entries, else a hash of the address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (src_mem.exists(a)) return src_mem[a];
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // Memory port model: choose ready, predict and check the request, apply
    // fires, then pick one response for the coming rising edge.
    always @(negedge clk) begin : mem_model
        txn_t  cur, exp;
        logic  exp_valid;
        frsp_t f;
        int    cands [$];
        int    t;
        cur = {mem_req_rw, mem_req_tag, mem_req_addr, mem_req_data};
        if (!reset) begin
            mem_rsp_valid = 1'b0;
            mem_rsp_tag   = '0;
            mem_rsp_data  = '0;
            mem_req_ready = 1'b0;
            m_active      = 1'b0;
            prev_hold     = 1'b0;
            for (int i = 0; i < NS; i++) m_st[i] = M_FREE;
        end else begin
            mem_req_ready = (cyc >= stall_until) && (!rdy_rand || ($urandom_range(0, 3) != 0));

            if (prev_hold) begin
                check("req_held_valid", 128'(mem_req_valid), 128'(1));
                check("req_held_fields", 128'(cur), 128'(prev_fields));
            end else begin
                exp_valid = 1'b0;
                exp       = '0;
                if (m_active) begin
                    for (int i = 0; i < NS; i++)
                        if (!exp_valid && m_st[i] == M_FULL) begin
                            exp_valid = 1'b1;
                            exp = {1'b1, SB'(i), m_dst + m_off[i], m_data[i]};
                        end
                    if (m_rd < m_len)
                        for (int i = 0; i < NS; i++)
                            if (!exp_valid && m_st[i] == M_FREE) begin
                                exp_valid = 1'b1;
                                exp = {1'b0, SB'(i), m_src + 32'(m_rd), 32'h0};
                            end
                end
                check("req_valid", 128'(mem_req_valid), 128'(exp_valid));
                if (exp_valid && mem_req_valid) check("req_fields", 128'(cur), 128'(exp));
            end

            if (mem_req_valid && mem_req_ready) begin
                txn_log.push_back(cur);
                t = int'(mem_req_tag);
                if (m_active) begin
                    if (mem_req_rw) begin
                        m_st[t] = M_FREE;
                        m_wr++;
                        if (m_wr == m_len) m_active = 1'b0;
                    end else begin
                        m_st[t]  = M_PEND;
                        m_off[t] = 32'(m_rd);
                        m_due[t] = cyc + $urandom_range(lat_min, lat_max);
                        m_rd++;
                    end
                end
            end
            prev_hold   = mem_req_valid && !mem_req_ready;
            prev_fields = cur;

            if (cmd_valid && cmd_ready) begin
                m_src    = cmd_src_addr;
                m_dst    = cmd_dst_addr;
                m_len    = int'(cmd_len);
                m_rd     = 0;
                m_wr     = 0;
                m_active = (cmd_len != '0);
                for (int i = 0; i < NS; i++) m_st[i] = M_FREE;
            end

            mem_rsp_valid = 1'b0;
            mem_rsp_tag   = '0;
            mem_rsp_data  = '0;
            if (force_q.size() > 0) begin
                f = force_q.pop_front();
                t = int'(f.tag);
                mem_rsp_valid = 1'b1;
                mem_rsp_tag   = f.tag;
                if (m_st[t] == M_PEND) begin
                    mem_rsp_data = word_at(m_src + m_off[t]);
                    m_st[t]      = M_FULL;
                    m_data[t]    = mem_rsp_data;
                end else begin
                    mem_rsp_data = f.data;
                end
            end else if (rsp_auto) begin
                cands.delete();
                for (int i = 0; i < NS; i++)
                    if (m_st[i] == M_PEND && m_due[i] <= cyc) cands.push_back(i);
                if (cands.size() > 0) begin
                    t = cands[$urandom_range(0, cands.size() - 1)];
                    mem_rsp_valid = 1'b1;
                    mem_rsp_tag   = SB'(t);
                    mem_rsp_data  = word_at(m_src + m_off[t]);
                    m_st[t]       = M_FULL;
                    m_data[t]     = mem_rsp_data;
                end
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge + 1) ----------------
    task automatic issue(input logic [31:0] s, input logic [31:0] d, input int len, input logic [7:0] tag);
        check("cmd_ready_idle", 128'(cmd_ready), 128'(1));
        cmd_valid    = 1'b1;
        cmd_src_addr = s;
        cmd_dst_addr = d;
        cmd_len      = LW'(len);
        cmd_tag      = tag;
        @(posedge clk); #1;
        cmd_valid    = 1'b0;
    endtask

    task automatic wait_done(input logic [7:0] tag, input int budget, input int delay);
        int n = 0;
        while (!done_valid && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done_valid) begin
            check("done_timeout", 128'(0), 128'(1));
            return;
        end
        check("done_tag", 128'(done_tag), 128'(tag));
        check("writes_total", 128'(m_wr), 128'(m_len));
        check("reads_total", 128'(m_rd), 128'(m_len));
        for (int i = 0; i < delay; i++) begin
            @(posedge clk); #1;
            check("done_held", 128'(done_valid), 128'(1));
        end
        done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
        check("busy_after_done", 128'(busy), 128'(0));
        check("cmd_ready_after_done", 128'(cmd_ready), 128'(1));
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_cmd_ready"}, 128'(cmd_ready), 128'(1));
        check({pfx, "_req_valid"}, 128'(mem_req_valid), 128'(0));
        check({pfx, "_done_valid"}, 128'(done_valid), 128'(0));
        check({pfx, "_busy"}, 128'(busy), 128'(0));
        check({pfx, "_done_tag"}, 128'(done_tag), 128'(0));
        check({pfx, "_rsp_ready"}, 128'(mem_rsp_ready), 128'(1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_src_addr = '0;
        cmd_dst_addr = '0;
        cmd_len      = '0;
        cmd_tag      = '0;
        done_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        // Single word, fixed 3-cycle memory latency.
        src_mem[32'h100] = 32'hDEAD_BEEF;
        lat_min = 3; lat_max = 3; rdy_rand = 1'b0;
        txn_log.delete();
        issue(32'h100, 32'h800, 1, 8'h5A);
        wait_done(8'h5A, 50, 0);
        check("t1_ntxn", 128'(txn_log.size()), 128'(2));
        if (txn_log.size() == 2) begin
            check("t1_read", 128'(txn_log[0]), 128'({1'b0, 2'd0, 32'h100, 32'h0}));
            check("t1_write", 128'(txn_log[1]), 128'({1'b1, 2'd0, 32'h800, 32'hDEAD_BEEF}));
        end

        // Responses withheld: only MAX_OUTS reads may be in flight.
        rsp_auto = 1'b0;
        txn_log.delete();
        issue(32'h2000, 32'h3000, 8, 8'h22);
        repeat (10) begin @(posedge clk); #1; end
        check("t2_reads_in_flight", 128'(txn_log.size()), 128'(4));
        for (int i = 0; i < 4 && i < txn_log.size(); i++)
            check("t2_read", 128'(txn_log[i]), 128'({1'b0, SB'(i), 32'h2000 + 32'(i), 32'h0}));
        rsp_auto = 1'b1; lat_min = 1; lat_max = 4;
        wait_done(8'h22, 200, 1);
        check("t2_ntxn", 128'(txn_log.size()), 128'(16));

        // Out-of-order returns 3,1,0,2 with ready held high.
        rsp_auto = 1'b0;
        txn_log.delete();
        issue(32'h40, 32'h7000, 4, 8'h33);
        repeat (6) begin @(posedge clk); #1; end
        check("t3_reads", 128'(txn_log.size()), 128'(4));
        force_q.push_back({2'd3, 32'h0});
        force_q.push_back({2'd1, 32'h0});
        force_q.push_back({2'd0, 32'h0});
        force_q.push_back({2'd2, 32'h0});
        wait_done(8'h33, 50, 0);
        rsp_auto = 1'b1;
        check("t3_ntxn", 128'(txn_log.size()), 128'(8));
        if (txn_log.size() == 8) begin
            logic [1:0] ord [4];
            ord = '{2'd3, 2'd1, 2'd0, 2'd2};
            for (int i = 0; i < 4; i++)
                check("t3_write", 128'(txn_log[4 + i]),
                      128'({1'b1, ord[i], 32'h7000 + 32'(ord[i]), word_at(32'h40 + 32'(ord[i]))}));
        end

        // Five-cycle ready stall mid-run.
        lat_min = 1; lat_max = 3;
        issue(32'h1_0000, 32'h2_0000, 12, 8'h44);
        repeat (4) begin @(posedge clk); #1; end
        stall_until = cyc + 5;
        repeat (4) begin @(posedge clk); #1; end
        check("t4_stall_valid", 128'(mem_req_valid), 128'(1));
        wait_done(8'h44, 300, 0);

        // Zero-length command.
        txn_log.delete();
        issue(32'h0, 32'h0, 0, 8'h11);
        check("t5_done_cycle1", 128'(done_valid), 128'(1));
        check("t5_done_tag", 128'(done_tag), 128'(8'h11));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("t5_done_held", 128'(done_valid), 128'(1));
            check("t5_cmd_ready_low", 128'(cmd_ready), 128'(0));
        end
        check("t5_no_mem", 128'(txn_log.size()), 128'(0));
        done_ready = 1'b1;
        @(posedge clk); #1;
        done_ready = 1'b0;
        check("t5_idle", 128'(busy), 128'(0));

        // Reset mid-run with two reads pending, then stale responses.
        rsp_auto = 1'b0;
        txn_log.delete();
        issue(32'h500, 32'h900, 6, 8'h66);
        for (int n = 0; n < 20 && txn_log.size() < 2; n++) begin @(posedge clk); #1; end
        check("t6_pending", 128'(txn_log.size()), 128'(2));
        #2 reset = 1'b0;
        #1 check_reset_outputs("t6_async");
        @(posedge clk); #1;
        reset = 1'b1;
        force_q.push_back({2'd0, 32'hBAD0_0000});
        force_q.push_back({2'd1, 32'hBAD1_0000});
        repeat (4) begin @(posedge clk); #1; end
        check("t6_stale_no_req", 128'(mem_req_valid), 128'(0));
        check("t6_stale_no_done", 128'(done_valid), 128'(0));
        rsp_auto = 1'b1;
        issue(32'h600, 32'hA00, 2, 8'h77);
        wait_done(8'h77, 100, 0);

        // Randomized commands, random ready and latency, some wrapping.
        rdy_rand = 1'b1; lat_min = 1; lat_max = 8;
        for (int k = 0; k < 12; k++) begin
            logic [31:0] s, d;
            int          l;
            logic [7:0]  tg;
            s  = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom();
            d  = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFF4 : $urandom();
            l  = $urandom_range(1, 24);
            tg = 8'($urandom());
            issue(s, d, l, tg);
            wait_done(tg, 2000, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
